// File: rtl/puf_challenge_sequencer.sv
// Challenge/response sequencer for the byte-wide arbiter PUF: steps an LFSR challenge,
// settles, majority-votes repeated response samples and assembles the response word.
module puf_challenge_sequencer #(
    parameter int unsigned RESP_BITS     = 32,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned VOTES         = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           seed,
    input  logic                 response_in,
    output logic [7:0]           challenge,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic [5:0]           unstable_cnt
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    VOTE_LAST   = 4'(VOTES - 1);
    localparam logic [3:0]    VOTE_HALF   = 4'(VOTES / 2);
    localparam logic [3:0]    VOTE_ALL    = 4'(VOTES);
    localparam logic [5:0]    BIT_LAST    = 6'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t               r_state,      w_state_nxt;
    logic [7:0]           r_challenge,  w_challenge_nxt;
    logic                 r_busy,       w_busy_nxt;
    logic                 r_done,       w_done_nxt;
    logic [RESP_BITS-1:0] r_response,   w_response_nxt;
    logic [5:0]           r_unstable,   w_unstable_nxt;
    logic [5:0]           r_bit_cnt,    w_bit_cnt_nxt;
    logic [SW-1:0]        r_settle_cnt, w_settle_cnt_nxt;
    logic [3:0]           r_vote_cnt,   w_vote_cnt_nxt;
    logic [3:0]           r_ones,       w_ones_nxt;
    logic                 w_bit;

    // x^8+x^6+x^5+x^4+1, maximal length; never reaches zero from a nonzero state
    function automatic logic [7:0] lfsr_next(input logic [7:0] c);
        return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    endfunction

    always_comb begin
        w_state_nxt      = r_state;
        w_challenge_nxt  = r_challenge;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_response_nxt   = r_response;
        w_unstable_nxt   = r_unstable;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_settle_cnt_nxt = r_settle_cnt;
        w_vote_cnt_nxt   = r_vote_cnt;
        w_ones_nxt       = r_ones;
        w_bit            = (r_ones > VOTE_HALF);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_challenge_nxt  = (seed == 8'h00) ? 8'h01 : seed;
                    w_response_nxt   = '0;
                    w_unstable_nxt   = '0;
                    w_bit_cnt_nxt    = '0;
                    w_settle_cnt_nxt = '0;
                    w_busy_nxt       = 1'b1;
                    w_state_nxt      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_settle_cnt_nxt = r_settle_cnt + SW'(1);
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_vote_cnt_nxt = '0;
                    w_ones_nxt     = '0;
                    w_state_nxt    = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_ones_nxt     = r_ones + {3'b000, response_in};
                w_vote_cnt_nxt = r_vote_cnt + 4'd1;
                if (r_vote_cnt == VOTE_LAST) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_response_nxt  = {r_response[RESP_BITS-2:0], w_bit};
                if (r_ones != 4'd0 && r_ones != VOTE_ALL && r_unstable != 6'd63) begin
                    w_unstable_nxt = r_unstable + 6'd1;
                end
                w_challenge_nxt = lfsr_next(r_challenge);
                w_bit_cnt_nxt   = r_bit_cnt + 6'd1;
                if (r_bit_cnt == BIT_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_settle_cnt_nxt = '0;
                    w_state_nxt      = S_SETTLE;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_challenge  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_response   <= '0;
            r_unstable   <= '0;
            r_bit_cnt    <= '0;
            r_settle_cnt <= '0;
            r_vote_cnt   <= '0;
            r_ones       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_challenge  <= w_challenge_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_response   <= w_response_nxt;
            r_unstable   <= w_unstable_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_vote_cnt   <= w_vote_cnt_nxt;
            r_ones       <= w_ones_nxt;
        end
    end

    assign challenge    = r_challenge;
    assign busy         = r_busy;
    assign done         = r_done;
    assign response     = r_response;
    assign unstable_cnt = r_unstable;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer: default-parameter runs plus a small
// 8-bit / 1-settle / 1-vote instance.
module tb_puf_challenge_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  seed;
    logic        resp_drv;
    logic        follow_chal;
    logic        w_resp_in;
    logic [7:0]  challenge;
    logic        busy;
    logic        done;
    logic [31:0] response;
    logic [5:0]  unstable_cnt;

    logic        start1;
    logic [7:0]  seed1;
    logic [7:0]  challenge1;
    logic        busy1;
    logic        done1;
    logic [7:0]  response1;
    logic [5:0]  unstable1;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    assign w_resp_in = follow_chal ? challenge[0] : resp_drv;

    puf_challenge_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed),
        .response_in  (w_resp_in),
        .challenge    (challenge),
        .busy         (busy),
        .done         (done),
        .response     (response),
        .unstable_cnt (unstable_cnt)
    );

    puf_challenge_sequencer #(
        .RESP_BITS     (8),
        .SETTLE_CYCLES (1),
        .VOTES         (1)
    ) dut_small (
        .clk          (clk),
        .rst          (rst),
        .start        (start1),
        .seed         (seed1),
        .response_in  (1'b0),
        .challenge    (challenge1),
        .busy         (busy1),
        .done         (done1),
        .response     (response1),
        .unstable_cnt (unstable1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_f(input logic [7:0] c);
        return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    endfunction

    function automatic logic [31:0] follow_resp(input logic [7:0] s);
        logic [7:0]  c;
        logic [31:0] r;
        c = (s == 8'h00) ? 8'h01 : s;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            r = {r[30:0], c[0]};
            c = lfsr_f(c);
        end
        return r;
    endfunction

    // mode 0: tied 0, 1: tied 1, 2: follow challenge[0], 3: 1,0,1 votes, 4: 0,1,0 votes
    task automatic drive_resp(input int n, input int mode);
        int ph;
        bit smp;
        ph  = n % 8;
        smp = (ph >= 5);
        follow_chal = (mode == 2);
        case (mode)
            0:       resp_drv = 1'b0;
            1:       resp_drv = 1'b1;
            3:       resp_drv = smp ? (ph != 6) : 1'b0;
            4:       resp_drv = smp ? (ph == 6) : 1'b1;
            default: resp_drv = 1'b0;
        endcase
    endtask

    task automatic do_run(input string name, input logic [7:0] seed_v, input int mode,
                          input bit poke, input logic [31:0] exp_resp, input logic [5:0] exp_unst);
        logic [7:0] exp_ch;
        int done_edge;
        int done_cnt;
        done_edge = -1;
        done_cnt  = 0;
        exp_ch    = (seed_v == 8'h00) ? 8'h01 : seed_v;
        seed      = seed_v;
        start     = 1'b1;
        drive_resp(0, mode);
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_acc_busy"}, 32'(busy), 32'd1);
        chk({name, "_acc_chal"}, 32'(challenge), 32'(exp_ch));
        chk({name, "_acc_resp"}, response, 32'd0);
        for (int n = 1; n <= 260; n++) begin
            drive_resp(n, mode);
            start = poke && (n == 100 || n == 257);
            @(posedge clk); #1;
            if (n % 8 == 0 && n <= 256) exp_ch = lfsr_f(exp_ch);
            if (n % 8 == 7 && n <= 256) chk({name, "_chal"}, 32'(challenge), 32'(exp_ch));
            if (done) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = n;
                    chk({name, "_done_busy"}, 32'(busy), 32'd0);
                    chk({name, "_done_resp"}, response, exp_resp);
                    chk({name, "_done_unst"}, 32'(unstable_cnt), 32'(exp_unst));
                end
            end
        end
        start = 1'b0;
        chk({name, "_done_edge"}, 32'(done_edge), 32'd256);
        chk({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
        chk({name, "_final_chal"}, 32'(challenge), 32'(exp_ch));
        chk({name, "_held_resp"}, response, exp_resp);
    endtask

    initial begin
        logic [7:0]  exp_c;
        logic [31:0] exp_r;
        int d_edge;
        rst = 1'b1; start = 1'b0; seed = 8'h00; resp_drv = 1'b0; follow_chal = 1'b0;
        start1 = 1'b0; seed1 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_chal", 32'(challenge), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_resp", response, 32'd0);
        chk("rst_unst", 32'(unstable_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold_busy", 32'(busy), 32'd0);

        do_run("ones", 8'h5A, 1, 1'b0, 32'hFFFF_FFFF, 6'd0);

        exp_r = follow_resp(8'h00);
        do_run("follow", 8'h00, 2, 1'b0, exp_r, 6'd0);
        chk("follow_top_byte", 32'(response[31:24]), 32'h8E);

        do_run("vote101", 8'h3C, 3, 1'b0, 32'hFFFF_FFFF, 6'd32);
        do_run("vote010", 8'hC3, 4, 1'b0, 32'h0000_0000, 6'd32);

        exp_r = follow_resp(8'h5A);
        do_run("poke", 8'h5A, 2, 1'b1, exp_r, 6'd0);

        // mid-run reset
        seed = 8'h33; start = 1'b1; drive_resp(0, 1);
        @(posedge clk); #1;
        start = 1'b0;
        d_edge = -1;
        for (int n = 1; n <= 130; n++) begin
            drive_resp(n, 1);
            if (n == 130) rst = 1'b1;
            @(posedge clk); #1;
            if (done && d_edge < 0) d_edge = n;
        end
        chk("abort_chal", 32'(challenge), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_resp", response, 32'd0);
        chk("abort_unst", 32'(unstable_cnt), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (done && d_edge < 0) d_edge = 1000 + n;
        end
        chk("abort_no_done", 32'(d_edge), 32'hFFFF_FFFF);
        do_run("rerun", 8'h01, 1, 1'b0, 32'hFFFF_FFFF, 6'd0);

        // small instance: 8 bits x (1 settle + 1 vote + 1 shift) = 24 edges
        exp_c = 8'h5A;
        for (int i = 0; i < 8; i++) exp_c = lfsr_f(exp_c);
        seed1 = 8'h5A; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("small_acc_chal", 32'(challenge1), 32'h5A);
        d_edge = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done1 && d_edge < 0) begin
                d_edge = n;
                chk("small_done_busy", 32'(busy1), 32'd0);
                chk("small_done_resp", 32'(response1), 32'd0);
                chk("small_done_unst", 32'(unstable1), 32'd0);
                chk("small_done_chal", 32'(challenge1), 32'(exp_c));
            end
        end
        chk("small_done_edge", 32'(d_edge), 32'd24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
